motion_executor: RTL and testbench
==================================

# motion_executor

Executes the movement and turn commands issued by the car's autonomous-drive controller. Converts the level-sensitive move requests and the turn trigger pulses into registered motor-control outputs. Times each turn with a cycle counter, tracks the car's 2-bit heading, and returns the `moving` / `is_turning` status the controller uses to sequence its next decision. Sits between the autonomous-drive controller and the motor and simulation output logic.

## Interface
Parameters:
- `TURN_CYCLES`, default 50_000_000: number of cycles a 90° turn takes; a turn-back takes 2×`TURN_CYCLES`. Must be ≥ 1.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  block active; low forces the idle state.
- `move_forward`  input  1  level request: drive forward.
- `move_backward`  input  1  level request: drive backward.
- `trigger_turn_left`  input  1  turn-left request; acted on at its rising edge.
- `trigger_turn_right`  input  1  turn-right request; acted on at its rising edge.
- `trigger_turn_back`  input  1  180° turn request; acted on at its rising edge.
- `moving`  output  1  car translating forward or backward.
- `is_turning`  output  1  turn in progress.
- `motor_fwd`  output  1  forward drive.
- `motor_bwd`  output  1  backward drive.
- `motor_left`  output  1  left-rotation drive.
- `motor_right`  output  1  right-rotation drive.
- `heading`  output  2  0=N, 1=E, 2=S, 3=W.

## Operation
- **States:** IDLE, FWD, BWD, TURN_L, TURN_R, TURN_B. All outputs are registered.
- **Reset:**
  - State goes to IDLE; counter clears to 0; `heading` = 0.
  - All other outputs go to 0.
  - The three trigger-history registers reset to 0, so a trigger already high when reset is released counts as an edge.
- **Edge detect:** an edge on a trigger is `trig & ~trig_q`. History registers update every cycle, including during a turn and while `enable` is low.
- **Starting a turn:** from IDLE, FWD or BWD, a detected edge enters a turn state.
  - Simultaneous edges resolve by priority: back > left > right.
  - A turn preempts any move request.
  - The counter loads `TURN_CYCLES-1`, or `2*TURN_CYCLES-1` for TURN_B.
- **During a turn:**
  - The counter decrements each cycle.
  - When the counter reaches 0, the state leaves the turn and `heading` updates on that same edge:
    - TURN_R: +1.
    - TURN_L: +3.
    - TURN_B: +2.
    - All heading arithmetic is mod 4 (2-bit wrap).
  - Trigger edges are ignored and not queued.
  - Move inputs are ignored.
- **Non-turn state selection** (from IDLE/FWD/BWD with no edge, and on leaving a turn), by the current inputs:
  - `move_forward & ~move_backward` → FWD.
  - `move_backward & ~move_forward` → BWD.
  - Otherwise → IDLE; both requests high means stop.
- **Output decode** (registered from next state):
  - FWD: `motor_fwd` = 1, `moving` = 1.
  - BWD: `motor_bwd` = 1, `moving` = 1.
  - TURN_L: `motor_left` = 1, `is_turning` = 1.
  - TURN_R and TURN_B: `motor_right` = 1, `is_turning` = 1.
  - At most one motor output is high at any time.
- **`enable` low:**
  - Next cycle: state goes to IDLE, counter clears, all motor/status outputs are 0.
  - A turn in progress is aborted and `heading` is unchanged.
  - Edges seen while disabled are discarded.
- **Counter width:** `$clog2(2*TURN_CYCLES)`, minimum 1 bit; it never underflows.

## Timing
- **Turn start:** trigger edge sampled at edge N; `is_turning` and the motor output are high from edge N+1.
- **Turn duration:** `is_turning` stays high for exactly `TURN_CYCLES` cycles, or 2×`TURN_CYCLES` for a turn-back.
- **Turn end:** `is_turning` falls and `heading` changes on the same edge.
  - If a move request is active at that point, `moving` rises on that same edge.
- **Move requests:** a change on `move_*` is reflected in `moving` / `motor_*` one edge later.
- **Re-trigger:** a trigger held high for many cycles causes one turn only. A new edge at the exact end-of-turn edge is ignored. An edge in the following cycle starts a new turn.
- **Reset mid-turn:** all outputs are 0 and `heading` is 0 after the reset edge.

## Test plan
- **Reset release:** reset, then release with all inputs 0 → all outputs 0, `heading` = 0.
- **Right turn** (`TURN_CYCLES` = 4): one-cycle `trigger_turn_right` pulse → `is_turning` and `motor_right` high for exactly 4 cycles starting the next edge, then `heading` = 1.
- **Left-turn wrap:** from `heading` = 0, one left pulse → after 4 cycles `heading` = 3. A following turn-back → after 8 cycles `heading` = 1.
- **Simultaneous triggers:** left and back edges in the same cycle → 8-cycle turn, `heading` += 2. Right pulse during the turn → ignored, `heading` unchanged by it.
- **Move then turn:** `move_forward` held, left pulse on cycle 10 → `moving` drops and `motor_left` rises; 4 cycles later `moving`/`motor_fwd` return on the same edge `is_turning` falls. Both move inputs high → IDLE.
- **Disable mid-turn:** `enable` dropped 2 cycles into a turn → next edge all outputs 0, `heading` unchanged. Re-enable → no spurious turn.

Source files
------------

// File: rtl/motion_executor.sv
// rtl/motion_executor.sv - movement/turn command executor with turn timer and heading tracker
//
// Purpose: turns level move requests and rising-edge turn triggers into
// registered motor drives, times each turn with a down-counter and keeps
// the car's 2-bit heading (0=N, 1=E, 2=S, 3=W).
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst                 in   synchronous active-high reset
//   enable              in   block active; low forces idle
//   move_forward        in   level request, drive forward
//   move_backward       in   level request, drive backward
//   trigger_turn_left   in   rising edge starts a 90 deg left turn
//   trigger_turn_right  in   rising edge starts a 90 deg right turn
//   trigger_turn_back   in   rising edge starts a 180 deg turn
//   moving              out  translating forward or backward
//   is_turning          out  turn in progress
//   motor_fwd/bwd/left/right out  one-hot motor drives
//   heading             out  [1:0] current heading
module motion_executor #(
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       move_forward,
    input  logic       move_backward,
    input  logic       trigger_turn_left,
    input  logic       trigger_turn_right,
    input  logic       trigger_turn_back,
    output logic       moving,
    output logic       is_turning,
    output logic       motor_fwd,
    output logic       motor_bwd,
    output logic       motor_left,
    output logic       motor_right,
    output logic [1:0] heading
);

    localparam int CW_RAW = $clog2(2 * TURN_CYCLES);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LOAD_90  = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_180 = CW'(2 * TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_BWD,
        S_TURN_L,
        S_TURN_R,
        S_TURN_B
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    heading_q, heading_d;
    logic [2:0]    trig_q, trig_d;   // {back, left, right} history
    logic          moving_q, moving_d;
    logic          turning_q, turning_d;
    logic          fwd_q, fwd_d;
    logic          bwd_q, bwd_d;
    logic          left_q, left_d;
    logic          right_q, right_d;

    logic   edge_l, edge_r, edge_b;
    state_t move_state;

    always_comb begin
        trig_d = {trigger_turn_back, trigger_turn_left, trigger_turn_right};
        edge_b = trigger_turn_back  & ~trig_q[2];
        edge_l = trigger_turn_left  & ~trig_q[1];
        edge_r = trigger_turn_right & ~trig_q[0];

        // Both requests high (or neither) means stop.
        move_state = S_IDLE;
        if (move_forward && !move_backward) begin
            move_state = S_FWD;
        end else if (move_backward && !move_forward) begin
            move_state = S_BWD;
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        heading_d = heading_q;

        if (!enable) begin
            // Abort anything in progress; heading keeps its last committed value.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_TURN_L, S_TURN_R, S_TURN_B: begin
                    // Triggers and move requests are not looked at until the turn ends.
                    if (cnt_q == '0) begin
                        state_d = move_state;
                        case (state_q)
                            S_TURN_L: heading_d = heading_q + 2'd3;
                            S_TURN_R: heading_d = heading_q + 2'd1;
                            default:  heading_d = heading_q + 2'd2;
                        endcase
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    if (edge_b) begin
                        state_d = S_TURN_B;
                        cnt_d   = LOAD_180;
                    end else if (edge_l) begin
                        state_d = S_TURN_L;
                        cnt_d   = LOAD_90;
                    end else if (edge_r) begin
                        state_d = S_TURN_R;
                        cnt_d   = LOAD_90;
                    end else begin
                        state_d = move_state;
                    end
                end
            endcase
        end

        // Outputs are registered decodes of the next state.
        fwd_d     = (state_d == S_FWD);
        bwd_d     = (state_d == S_BWD);
        left_d    = (state_d == S_TURN_L);
        right_d   = (state_d == S_TURN_R) || (state_d == S_TURN_B);
        moving_d  = fwd_d | bwd_d;
        turning_d = left_d | right_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            heading_q <= 2'd0;
            trig_q    <= 3'b000;
            moving_q  <= 1'b0;
            turning_q <= 1'b0;
            fwd_q     <= 1'b0;
            bwd_q     <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            heading_q <= heading_d;
            trig_q    <= trig_d;
            moving_q  <= moving_d;
            turning_q <= turning_d;
            fwd_q     <= fwd_d;
            bwd_q     <= bwd_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign moving      = moving_q;
    assign is_turning  = turning_q;
    assign motor_fwd   = fwd_q;
    assign motor_bwd   = bwd_q;
    assign motor_left  = left_q;
    assign motor_right = right_q;
    assign heading     = heading_q;

endmodule

// File: tb/tb_motion_executor.sv
// tb/tb_motion_executor.sv - directed self-checking bench for motion_executor
module tb_motion_executor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       move_forward;
    logic       move_backward;
    logic       trigger_turn_left;
    logic       trigger_turn_right;
    logic       trigger_turn_back;
    logic       moving;
    logic       is_turning;
    logic       motor_fwd;
    logic       motor_bwd;
    logic       motor_left;
    logic       motor_right;
    logic [1:0] heading;

    int checks = 0;
    int errors = 0;

    motion_executor #(.TURN_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .move_forward       (move_forward),
        .move_backward      (move_backward),
        .trigger_turn_left  (trigger_turn_left),
        .trigger_turn_right (trigger_turn_right),
        .trigger_turn_back  (trigger_turn_back),
        .moving             (moving),
        .is_turning         (is_turning),
        .motor_fwd          (motor_fwd),
        .motor_bwd          (motor_bwd),
        .motor_left         (motor_left),
        .motor_right        (motor_right),
        .heading            (heading)
    );

    always #5 clk = ~clk;

    // Expected output bundles: {moving, is_turning, fwd, bwd, left, right, heading}
    function automatic logic [7:0] o_idle(input logic [1:0] h);
        return {6'b000000, h};
    endfunction
    function automatic logic [7:0] o_fwd(input logic [1:0] h);
        return {6'b101000, h};
    endfunction
    function automatic logic [7:0] o_bwd(input logic [1:0] h);
        return {6'b100100, h};
    endfunction
    function automatic logic [7:0] o_left(input logic [1:0] h);
        return {6'b010010, h};
    endfunction
    function automatic logic [7:0] o_right(input logic [1:0] h);
        return {6'b010001, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {moving, is_turning, motor_fwd, motor_bwd, motor_left, motor_right, heading};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        move_forward = 1'b0; move_backward = 1'b0;
        trigger_turn_left = 1'b0; trigger_turn_right = 1'b0; trigger_turn_back = 1'b0;
        @(negedge clk);
        tick();
        chk("in_reset", o_idle(2'd0));
        rst = 1'b0;
        tick();
        chk("reset_release", o_idle(2'd0));

        // Right turn: 4 turning cycles, then heading 1
        trigger_turn_right = 1'b1;
        tick();
        trigger_turn_right = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("right_turn_c%0d", i), o_right(2'd0));
            tick();
        end
        chk("right_done", o_idle(2'd1));

        // Reset back to heading 0, then left turn wraps to 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_heading", o_idle(2'd0));
        trigger_turn_left = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("left_turn_c%0d", i), o_left(2'd0));
            tick();
        end
        chk("left_wrap", o_idle(2'd3));

        // Turn-back: 8 cycles on the right motor, 3+2 -> 1
        trigger_turn_back = 1'b1;
        tick();
        trigger_turn_back = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("back_turn_c%0d", i), o_right(2'd3));
            tick();
        end
        chk("back_done", o_idle(2'd1));

        // Left and back together: back wins; right pulse mid-turn ignored
        trigger_turn_left = 1'b1;
        trigger_turn_back = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        trigger_turn_back = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("simul_turn_c%0d", i), o_right(2'd1));
            trigger_turn_right = (i == 2);
            tick();
        end
        trigger_turn_right = 1'b0;
        chk("simul_done", o_idle(2'd3));
        tick();
        chk("simul_no_queue", o_idle(2'd3));

        // Held trigger: one turn only, also not re-armed at the end-of-turn edge
        trigger_turn_right = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("held_turn_c%0d", i), o_right(2'd3));
            tick();
        end
        chk("held_done", o_idle(2'd0));
        tick();
        chk("held_single", o_idle(2'd0));
        trigger_turn_right = 1'b0;

        // Move forward, then left turn preempts, forward resumes at turn end
        move_forward = 1'b1;
        tick();
        chk("fwd_start", o_fwd(2'd0));
        for (int i = 0; i < 9; i++) tick();
        chk("fwd_hold", o_fwd(2'd0));
        trigger_turn_left = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mv_left_c%0d", i), o_left(2'd0));
            tick();
        end
        chk("fwd_resume", o_fwd(2'd3));
        move_backward = 1'b1;
        tick();
        chk("both_stop", o_idle(2'd3));
        move_forward = 1'b0;
        tick();
        chk("bwd_only", o_bwd(2'd3));
        move_backward = 1'b0;
        tick();
        chk("move_release", o_idle(2'd3));

        // Disable two cycles into a turn: abort, heading kept
        trigger_turn_right = 1'b1;
        tick();
        trigger_turn_right = 1'b0;
        chk("dis_turn_c0", o_right(2'd3));
        tick();
        chk("dis_turn_c1", o_right(2'd3));
        enable = 1'b0;
        tick();
        chk("dis_abort", o_idle(2'd3));
        trigger_turn_left = 1'b1;
        tick();
        chk("dis_edge_dropped", o_idle(2'd3));
        enable = 1'b1;
        tick();
        chk("reenable_no_turn", o_idle(2'd3));
        trigger_turn_left = 1'b0;
        tick();
        chk("reenable_idle", o_idle(2'd3));

        // Reset mid-turn clears heading and outputs
        trigger_turn_back = 1'b1;
        tick();
        trigger_turn_back = 1'b0;
        chk("pre_reset_turn", o_right(2'd3));
        rst = 1'b1;
        tick();
        chk("reset_mid_turn", o_idle(2'd0));
        rst = 1'b0;
        tick();
        chk("post_reset", o_idle(2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
